multicycle_ctrl_fsm: RTL and testbench

Control unit of the multi-cycle CPU. It holds the 3-bit cycle state internally, computes the next state from state, opCode and zero, and drives every datapath control strobe for the current cycle. The block is a full control unit, not only a state register with next-state logic. It sits between the instruction register (opCode), the ALU (zero) and the PC, register file, ALU muxes and data memory.

---
 rtl/multicycle_ctrl_fsm_if.sv | 35 +++
 rtl/multicycle_ctrl_fsm.sv | 167 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multi-cycle CPU control unit and the datapath.
//   opCode, zero : datapath -> control (instruction opcode, ALU zero flag)
//   state        : control -> datapath (current cycle state, for trace)
//   PCWre..PCSrc : control -> datapath (per-cycle control strobes)
// modport slave  : the control unit
// modport master : the datapath side (or a testbench standing in for it)
interface multicycle_ctrl_fsm_if #(
    parameter int unsigned OPC_W = 6
);
    logic [OPC_W-1:0] opCode;
    logic             zero;
    logic [2:0]       state;
    logic             PCWre;
    logic             IRWre;
    logic             RegWre;
    logic             RegDst;
    logic             ALUSrcB;
    logic             ExtSel;
    logic [2:0]       ALUOp;
    logic             DataMemRW;
    logic             DBDataSrc;
    logic [1:0]       PCSrc;

    modport master (
        output opCode, zero,
        input  state, PCWre, IRWre, RegWre, RegDst, ALUSrcB, ExtSel, ALUOp,
               DataMemRW, DBDataSrc, PCSrc
    );

    modport slave (
        input  opCode, zero,
        output state, PCWre, IRWre, RegWre, RegDst, ALUSrcB, ExtSel, ALUOp,
               DataMemRW, DBDataSrc, PCSrc
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Control unit of the multi-cycle CPU: 3-bit cycle state register plus
// combinational next-state and control-strobe decode.
//   CLK : clock, rising edge
//   RST : asynchronous reset, active-high (forces state IF)
//   bus : slave side of multicycle_ctrl_fsm_if (opCode/zero in, strobes out)
// Only the state is registered; every strobe is decoded from state, opCode
// and zero in the current cycle.
module multicycle_ctrl_fsm #(
    parameter int unsigned      OPC_W    = 6,
    parameter logic [OPC_W-1:0] J_OPC    = 6'b111000,
    parameter logic [OPC_W-1:0] HALT_OPC = 6'b111111
) (
    input logic                  CLK,
    input logic                  RST,
    multicycle_ctrl_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        StIf    = 3'b000,
        StId    = 3'b001,
        StExeLs = 3'b010,
        StMem   = 3'b011,
        StWbL   = 3'b100,
        StExeBr = 3'b101,
        StExeAl = 3'b110,
        StWbAl  = 3'b111
    } state_e;

    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6'b000001);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b000010);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(6'b010000);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(6'b010001);
    localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(6'b010010);
    localparam logic [OPC_W-1:0] OP_SLT  = OPC_W'(6'b100111);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b110000);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b110001);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b110100);

    state_e state_q, state_d;

    // Opcode class and ALU-instruction field decode
    logic       is_al, is_ls, is_br, is_sw;
    logic [2:0] al_op;
    logic       al_srcb, al_ext, al_rdst;

    always_comb begin
        is_al   = 1'b0;
        is_ls   = 1'b0;
        is_br   = 1'b0;
        is_sw   = 1'b0;
        al_op   = 3'b000;
        al_srcb = 1'b0;
        al_ext  = 1'b0;
        al_rdst = 1'b0;
        case (bus.opCode)
            OP_ADD:  begin is_al = 1'b1; al_rdst = 1'b1; end
            OP_SUB:  begin is_al = 1'b1; al_rdst = 1'b1; al_op = 3'b001; end
            OP_ADDI: begin is_al = 1'b1; al_srcb = 1'b1; al_ext = 1'b1; end
            OP_OR:   begin is_al = 1'b1; al_rdst = 1'b1; al_op = 3'b010; end
            OP_AND:  begin is_al = 1'b1; al_rdst = 1'b1; al_op = 3'b011; end
            OP_ORI:  begin is_al = 1'b1; al_srcb = 1'b1; al_op = 3'b010; end
            OP_SLT:  begin is_al = 1'b1; al_rdst = 1'b1; al_op = 3'b100; end
            OP_SW:   begin is_ls = 1'b1; is_sw = 1'b1; end
            OP_LW:   is_ls = 1'b1;
            OP_BEQ:  is_br = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.PCWre     = 1'b0;
        bus.IRWre     = 1'b0;
        bus.RegWre    = 1'b0;
        bus.RegDst    = 1'b0;
        bus.ALUSrcB   = 1'b0;
        bus.ExtSel    = 1'b0;
        bus.ALUOp     = 3'b000;
        bus.DataMemRW = 1'b0;
        bus.DBDataSrc = 1'b0;
        bus.PCSrc     = 2'b00;
        unique case (state_q)
            StIf: begin
                bus.IRWre = 1'b1;
                state_d   = StId;
            end
            StId: begin
                // Jump and halt are tested first so parameter overrides win
                if (bus.opCode == HALT_OPC) begin
                    state_d = StId;
                end else if (bus.opCode == J_OPC) begin
                    bus.PCWre = 1'b1;
                    bus.PCSrc = 2'b10;
                    state_d   = StIf;
                end else if (is_al) begin
                    state_d = StExeAl;
                end else if (is_ls) begin
                    state_d = StExeLs;
                end else if (is_br) begin
                    state_d = StExeBr;
                end else begin
                    // NOP retires here: PC+4
                    bus.PCWre = 1'b1;
                    state_d   = StIf;
                end
            end
            StExeAl: begin
                bus.ALUOp   = al_op;
                bus.ALUSrcB = al_srcb;
                bus.ExtSel  = al_ext;
                state_d     = StWbAl;
            end
            StWbAl: begin
                // ALU controls held so the result stays stable during write-back
                bus.ALUOp   = al_op;
                bus.ALUSrcB = al_srcb;
                bus.ExtSel  = al_ext;
                bus.RegWre  = 1'b1;
                bus.RegDst  = al_rdst;
                bus.PCWre   = 1'b1;
                state_d     = StIf;
            end
            StExeLs: begin
                bus.ALUSrcB = 1'b1;
                bus.ExtSel  = 1'b1;
                state_d     = StMem;
            end
            StMem: begin
                bus.ALUSrcB = 1'b1;
                bus.ExtSel  = 1'b1;
                if (is_sw) begin
                    bus.DataMemRW = 1'b1;
                    bus.PCWre     = 1'b1;
                    state_d       = StIf;
                end else begin
                    state_d = StWbL;
                end
            end
            StWbL: begin
                bus.RegWre    = 1'b1;
                bus.DBDataSrc = 1'b1;
                bus.PCWre     = 1'b1;
                state_d       = StIf;
            end
            StExeBr: begin
                bus.ALUOp  = 3'b001;
                bus.ExtSel = 1'b1;
                bus.PCWre  = 1'b1;
                bus.PCSrc  = bus.zero ? 2'b01 : 2'b00;
                state_d    = StIf;
            end
            default: state_d = StIf;
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed testbench for multicycle_ctrl_fsm. Outputs are packed into one
// 16-bit vector {state, PCWre, IRWre, RegWre, RegDst, ALUSrcB, ExtSel, ALUOp,
// DataMemRW, DBDataSrc, PCSrc} and compared against hand-built constants
// on the falling clock edge.
module tb_multicycle_ctrl_fsm;

    logic CLK;
    logic RST;
    int   total;
    int   bad;

    multicycle_ctrl_fsm_if #(.OPC_W(6)) bus ();

    multicycle_ctrl_fsm #(
        .OPC_W   (6),
        .J_OPC   (6'b111000),
        .HALT_OPC(6'b111111)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    logic [15:0] obs;
    assign obs = {bus.state, bus.PCWre, bus.IRWre, bus.RegWre, bus.RegDst, bus.ALUSrcB,
                  bus.ExtSel, bus.ALUOp, bus.DataMemRW, bus.DBDataSrc, bus.PCSrc};

    function automatic logic [15:0] v(input logic [2:0] st, input logic pcw, input logic irw,
                                      input logic rgw, input logic rgd, input logic asb,
                                      input logic ext, input logic [2:0] aop,
                                      input logic dm, input logic dbs, input logic [1:0] pcs);
        return {st, pcw, irw, rgw, rgd, asb, ext, aop, dm, dbs, pcs};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and compare
    task automatic step(input string tag, input logic [15:0] exp);
        @(negedge CLK);
        check(tag, obs, exp);
    endtask

    logic [15:0] v_if, v_id;

    initial begin
        total = 0;
        bad   = 0;
        v_if  = v(3'b000, 0, 1, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00);
        v_id  = v(3'b001, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00);

        // Reset, released while opCode = add
        RST         = 1'b1;
        bus.opCode  = 6'b000000;
        bus.zero    = 1'b0;
        step("rst_during", v_if);
        RST = 1'b0;
        #1 check("rst_after", obs, v_if);
        step("add_id", v_id);
        step("add_exe", v(3'b110, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00));
        step("add_wb", v(3'b111, 1, 0, 1, 1, 0, 0, 3'b000, 0, 0, 2'b00));
        step("add_if", v_if);

        // sub
        bus.opCode = 6'b000001;
        step("sub_id", v_id);
        step("sub_exe", v(3'b110, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 2'b00));
        step("sub_wb", v(3'b111, 1, 0, 1, 1, 0, 0, 3'b001, 0, 0, 2'b00));
        step("sub_if", v_if);

        // addi: sign-extended immediate, writes rt
        bus.opCode = 6'b000010;
        step("addi_id", v_id);
        step("addi_exe", v(3'b110, 0, 0, 0, 0, 1, 1, 3'b000, 0, 0, 2'b00));
        step("addi_wb", v(3'b111, 1, 0, 1, 0, 1, 1, 3'b000, 0, 0, 2'b00));
        step("addi_if", v_if);

        // ori: zero-extended immediate
        bus.opCode = 6'b010010;
        step("ori_id", v_id);
        step("ori_exe", v(3'b110, 0, 0, 0, 0, 1, 0, 3'b010, 0, 0, 2'b00));
        step("ori_wb", v(3'b111, 1, 0, 1, 0, 1, 0, 3'b010, 0, 0, 2'b00));
        step("ori_if", v_if);

        // and, slt
        bus.opCode = 6'b010001;
        step("and_id", v_id);
        step("and_exe", v(3'b110, 0, 0, 0, 0, 0, 0, 3'b011, 0, 0, 2'b00));
        step("and_wb", v(3'b111, 1, 0, 1, 1, 0, 0, 3'b011, 0, 0, 2'b00));
        step("and_if", v_if);
        bus.opCode = 6'b100111;
        step("slt_id", v_id);
        step("slt_exe", v(3'b110, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 2'b00));
        step("slt_wb", v(3'b111, 1, 0, 1, 1, 0, 0, 3'b100, 0, 0, 2'b00));
        step("slt_if", v_if);

        // lw: five cycles
        bus.opCode = 6'b110001;
        step("lw_id", v_id);
        step("lw_exe", v(3'b010, 0, 0, 0, 0, 1, 1, 3'b000, 0, 0, 2'b00));
        step("lw_mem", v(3'b011, 0, 0, 0, 0, 1, 1, 3'b000, 0, 0, 2'b00));
        step("lw_wb", v(3'b100, 1, 0, 1, 0, 0, 0, 3'b000, 0, 1, 2'b00));
        step("lw_if", v_if);

        // sw: four cycles, memory write in MEM
        bus.opCode = 6'b110000;
        step("sw_id", v_id);
        step("sw_exe", v(3'b010, 0, 0, 0, 0, 1, 1, 3'b000, 0, 0, 2'b00));
        step("sw_mem", v(3'b011, 1, 0, 0, 0, 1, 1, 3'b000, 1, 0, 2'b00));
        step("sw_if", v_if);

        // beq taken then not taken
        bus.opCode = 6'b110100;
        bus.zero   = 1'b1;
        step("beq1_id", v_id);
        step("beq1_exe", v(3'b101, 1, 0, 0, 0, 0, 1, 3'b001, 0, 0, 2'b01));
        step("beq1_if", v_if);
        bus.zero = 1'b0;
        step("beq0_id", v_id);
        step("beq0_exe", v(3'b101, 1, 0, 0, 0, 0, 1, 3'b001, 0, 0, 2'b00));
        step("beq0_if", v_if);

        // jump and undefined opcode retire in ID
        bus.opCode = 6'b111000;
        step("j_id", v(3'b001, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b10));
        step("j_if", v_if);
        bus.opCode = 6'b101010;
        step("nop_id", v(3'b001, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00));
        step("nop_if", v_if);

        // Reset mid-instruction abandons it
        bus.opCode = 6'b000000;
        step("abort_id", v_id);
        step("abort_exe", v(3'b110, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00));
        #2 RST = 1'b1;
        #1 check("abort_rst", obs, v_if);
        @(negedge CLK);
        RST = 1'b0;
        #1 check("abort_rel", obs, v_if);
        step("abort_id2", v_id);

        // halt: hold in ID with PC frozen, then asynchronous reset
        bus.opCode = 6'b111111;
        for (int i = 0; i < 20; i++) begin
            step($sformatf("halt_%0d", i), v_id);
        end
        #2 RST = 1'b1;
        #1 check("halt_rst", obs, v_if);
        @(negedge CLK);
        RST = 1'b0;
        bus.opCode = 6'b111000;
        step("post_halt_id", v(3'b001, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b10));
        step("post_halt_if", v_if);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
